// File: rtl/crc32_pkg.sv
// ---------------------------------------------------------------------------
// crc32_pkg
// Shared constants, the control state type and the single-byte CRC step for
// the CRC-32/MPEG-2 stream engine (polynomial 0x04C11DB7, non-reflected,
// bit 7 of every byte shifted in first).
// ---------------------------------------------------------------------------
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY         = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT_DEFAULT = 32'hFFFFFFFF;
    // Register value left behind when a frame is followed by its own CRC,
    // most significant byte first.
    localparam logic [31:0] CRC32_RESIDUE      = 32'h00000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } crc32_state_t;

    // Fold one byte into the running CRC, MSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data_byte);
        logic [31:0] c;
        c = crc ^ {data_byte, 24'h000000};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ((c << 1) ^ CRC32_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_lane_fold.sv
// ---------------------------------------------------------------------------
// crc32_lane_fold
// Combinational fold of up to DATA_W/8 byte lanes into a CRC. Lane 0
// (data[7:0]) is folded first; lanes at or above lane_cnt pass the CRC
// through untouched.
// Ports:
//   crc_in   in  32        CRC before this beat
//   data     in  DATA_W    beat data, lane 0 in the low byte
//   lane_cnt in  CNT_W     number of low lanes to fold (0..DATA_W/8)
//   crc_out  out 32        CRC after folding
// ---------------------------------------------------------------------------
module crc32_lane_fold
    import crc32_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
) (
    input  logic [31:0]       crc_in,
    input  logic [DATA_W-1:0] data,
    input  logic [CNT_W-1:0]  lane_cnt,
    output logic [31:0]       crc_out
);

    localparam int LANES = DATA_W / 8;

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(lane_cnt)) begin
                crc_out = crc32_byte(crc_out, data[8*i +: 8]);
            end
        end
    end

endmodule

// File: rtl/crc32_stream.sv
// ---------------------------------------------------------------------------
// crc32_stream
// Streaming CRC-32/MPEG-2 engine. Accepts one DATA_W-bit beat per cycle,
// folds all lanes of ordinary beats and the kept lanes of the last beat, and
// presents the result one cycle after the last beat with a valid/ready
// handshake. Input is stalled while a result is waiting.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   in_data             beat data, lane 0 = in_data[7:0] folded first
//   in_keep             lane enables, only honoured on the last beat
//   in_last             marks the final beat of a frame
//   crc_valid/crc_ready result handshake
//   crc_out             register XOR XOROUT
//   crc_ok              residue check, only built with
//                       `define CRC32_STREAM_RESIDUE_CHECK_EN (else tied 0)
// ---------------------------------------------------------------------------
module crc32_stream
    import crc32_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter logic [31:0] INIT   = CRC32_INIT_DEFAULT,
    parameter logic [31:0] XOROUT = 32'h00000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_last,
    output logic                crc_valid,
    input  logic                crc_ready,
    output logic [31:0]         crc_out,
    output logic                crc_ok
);

    localparam int LANES = DATA_W / 8;
    localparam int CNT_W = $clog2(LANES + 1);

    crc32_state_t     state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [CNT_W-1:0] lane_cnt;
    logic [31:0]      fold_seed;
    logic [31:0]      fold_res;
    logic             accept;

    // Handshake outputs are forced low while reset is held so nothing is
    // accepted or presented during the reset cycle itself.
    assign in_ready  = !rst && (state_q != ST_HOLD);
    assign crc_valid = !rst && (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign crc_out   = crc_q ^ XOROUT;

    // in_keep is contiguous from lane 0, so its population count is the
    // number of lanes to fold.
    always_comb begin
        lane_cnt = CNT_W'(LANES);
        if (in_last) begin
            lane_cnt = '0;
            for (int i = 0; i < LANES; i++) begin
                lane_cnt = lane_cnt + CNT_W'(in_keep[i]);
            end
        end
    end

    // A frame's first beat starts from INIT rather than the stale register.
    assign fold_seed = (state_q == ST_IDLE) ? INIT : crc_q;

    crc32_lane_fold #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_fold (
        .crc_in   (fold_seed),
        .data     (in_data),
        .lane_cnt (lane_cnt),
        .crc_out  (fold_res)
    );

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    crc_d   = fold_res;
                    state_d = in_last ? ST_HOLD : ST_RUN;
                end
            end
            ST_HOLD: begin
                if (crc_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
        end
    end

`ifdef CRC32_STREAM_RESIDUE_CHECK_EN
    assign crc_ok = crc_valid && (crc_q == CRC32_RESIDUE);
`else
    assign crc_ok = 1'b0;
`endif

endmodule
